// File: rtl/enigma_step_ctrl.sv
// Enigma M3 step sequencer: accepts a letter, steps the three rotors (with the
// middle-rotor double step), lets the datapath settle, then holds the ciphertext.
module enigma_step_ctrl #(
    parameter int unsigned NOTCH1     = 16,
    parameter int unsigned NOTCH2     = 4,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       IN_VALID,
    input  logic [4:0] IN_LET,
    output logic       IN_READY,
    input  logic       CFG_LD,
    input  logic [1:0] CFG_SEL,
    input  logic [4:0] CFG_VAL,
    output logic [4:0] ROT_LET,
    input  logic [4:0] ROT_RES,
    output logic [4:0] R1,
    output logic [4:0] R2,
    output logic [4:0] R3,
    output logic       OUT_VALID,
    output logic [4:0] OUT_LET,
    input  logic       OUT_READY,
    output logic       BUSY
);

    localparam int unsigned LET_W = 5;
    localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [LET_W-1:0] LAST_LET = LET_W'(25);
    localparam logic [LET_W-1:0] N1       = LET_W'(NOTCH1);
    localparam logic [LET_W-1:0] N2       = LET_W'(NOTCH2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;

    // Rotor position advance, wrapping Z back to A.
    function automatic logic [LET_W-1:0] inc26(input logic [LET_W-1:0] x);
        return (x >= LAST_LET) ? '0 : x + LET_W'(1);
    endfunction

    // Configuration has priority over a letter request, so advertise not-ready then.
    assign IN_READY = (state == IDLE) && !CFG_LD && RST_N;
    assign BUSY     = (state != IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            R1         <= '0;
            R2         <= '0;
            R3         <= '0;
            ROT_LET    <= '0;
            OUT_LET    <= '0;
            OUT_VALID  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (CFG_LD) begin
                        if (CFG_VAL <= LAST_LET) begin
                            case (CFG_SEL)
                                2'd1:    R1 <= CFG_VAL;
                                2'd2:    R2 <= CFG_VAL;
                                2'd3:    R3 <= CFG_VAL;
                                default: ;
                            endcase
                        end
                    end else if (IN_VALID) begin
                        // Out-of-range letters are consumed without stepping.
                        if (IN_LET <= LAST_LET) begin
                            ROT_LET <= IN_LET;
                            state   <= STEP;
                        end
                    end
                end
                STEP: begin
                    // Middle rotor also steps when it sits on its own notch (double step).
                    R1 <= inc26(R1);
                    if ((R1 == N1) || (R2 == N2)) begin
                        R2 <= inc26(R2);
                    end
                    if (R2 == N2) begin
                        R3 <= inc26(R3);
                    end
                    settle_cnt <= '0;
                    state      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt == CNT_LAST) begin
                        OUT_LET   <= ROT_RES;
                        OUT_VALID <= 1'b1;
                        state     <= EMIT;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (OUT_READY) begin
                        OUT_VALID <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl: table of config loads / letters with
// hand-computed rotor positions and ciphertext, plus multi-cycle corner sequences.
module tb_enigma_step_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [4:0] in_let;
    logic       in_ready;
    logic       cfg_ld;
    logic [1:0] cfg_sel;
    logic [4:0] cfg_val;
    logic [4:0] rot_let;
    logic [4:0] rot_res;
    logic [4:0] r1, r2, r3;
    logic       out_valid;
    logic [4:0] out_let;
    logic       out_ready;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Stand-in datapath: cipher = (letter + 20 + fast rotor) mod 26.
    assign rot_res = 5'((int'(rot_let) + 20 + int'(r1)) % 26);

    enigma_step_ctrl dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .IN_VALID  (in_valid),
        .IN_LET    (in_let),
        .IN_READY  (in_ready),
        .CFG_LD    (cfg_ld),
        .CFG_SEL   (cfg_sel),
        .CFG_VAL   (cfg_val),
        .ROT_LET   (rot_let),
        .ROT_RES   (rot_res),
        .R1        (r1),
        .R2        (r2),
        .R3        (r3),
        .OUT_VALID (out_valid),
        .OUT_LET   (out_let),
        .OUT_READY (out_ready),
        .BUSY      (busy)
    );

    typedef struct {
        string      name;
        bit         is_load;
        logic [1:0] sel;
        logic [4:0] val;
        logic [4:0] e1, e2, e3, eout;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rotors(input string nm, input logic [4:0] e1, input logic [4:0] e2,
                                input logic [4:0] e3);
        check({nm, " R1"}, 32'(r1), 32'(e1));
        check({nm, " R2"}, 32'(r2), 32'(e2));
        check({nm, " R3"}, 32'(r3), 32'(e3));
    endtask

    // Present one letter, then wait (bounded) for the ciphertext.
    task automatic send_letter(input logic [4:0] l);
        int n = 0;
        while (!in_ready && n < 10) begin
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_let   = l;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("out_valid arrival", 32'(out_valid), 32'd1);
    endtask

    task automatic consume(input string nm);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({nm, " busy drop"}, 32'(busy), 32'd0);
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [4:0] val);
        cfg_ld  = 1'b1;
        cfg_sel = sel;
        cfg_val = val;
        tick();
        cfg_ld  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_let = '0; cfg_ld = 1'b0;
        cfg_sel = '0; cfg_val = '0; out_ready = 1'b0;

        tbl[0]  = '{"load R1=16",   1'b1, 2'd1, 5'd16, 5'd16, 5'd0,  5'd0,  5'd0};
        tbl[1]  = '{"load R2=3",    1'b1, 2'd2, 5'd3,  5'd16, 5'd3,  5'd0,  5'd0};
        tbl[2]  = '{"load R3=0",    1'b1, 2'd3, 5'd0,  5'd16, 5'd3,  5'd0,  5'd0};
        tbl[3]  = '{"carry letter", 1'b0, 2'd0, 5'd4,  5'd17, 5'd4,  5'd0,  5'd15};
        tbl[4]  = '{"double step",  1'b0, 2'd0, 5'd7,  5'd18, 5'd5,  5'd1,  5'd19};
        tbl[5]  = '{"load R1=25",   1'b1, 2'd1, 5'd25, 5'd25, 5'd5,  5'd1,  5'd0};
        tbl[6]  = '{"load R2=25",   1'b1, 2'd2, 5'd25, 5'd25, 5'd25, 5'd1,  5'd0};
        tbl[7]  = '{"load R3=25",   1'b1, 2'd3, 5'd25, 5'd25, 5'd25, 5'd25, 5'd0};
        tbl[8]  = '{"wrap letter",  1'b0, 2'd0, 5'd25, 5'd0,  5'd25, 5'd25, 5'd19};
        tbl[9]  = '{"load R1=16b",  1'b1, 2'd1, 5'd16, 5'd16, 5'd25, 5'd25, 5'd0};
        tbl[10] = '{"R2 wrap",      1'b0, 2'd0, 5'd1,  5'd17, 5'd0,  5'd25, 5'd12};
        tbl[11] = '{"load val 27",  1'b1, 2'd1, 5'd27, 5'd17, 5'd0,  5'd25, 5'd0};
        tbl[12] = '{"load sel 0",   1'b1, 2'd0, 5'd3,  5'd17, 5'd0,  5'd25, 5'd0};
        tbl[13] = '{"load R2=4",    1'b1, 2'd2, 5'd4,  5'd17, 5'd4,  5'd25, 5'd0};
        tbl[14] = '{"R3 wrap",      1'b0, 2'd0, 5'd10, 5'd18, 5'd5,  5'd0,  5'd22};
        tbl[15] = '{"load R1=15",   1'b1, 2'd1, 5'd15, 5'd15, 5'd5,  5'd0,  5'd0};
        tbl[16] = '{"pre-notch",    1'b0, 2'd0, 5'd2,  5'd16, 5'd5,  5'd0,  5'd12};
        tbl[17] = '{"on notch",     1'b0, 2'd0, 5'd3,  5'd17, 5'd6,  5'd0,  5'd14};

        // Reset for two edges.
        tick();
        check("in_ready in reset", 32'(in_ready), 32'd0);
        tick();
        check_rotors("reset", 5'd0, 5'd0, 5'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("in_ready after reset", 32'(in_ready), 32'd1);

        // First letter, exact cycle timing.
        in_valid = 1'b1;
        in_let   = 5'd0;
        tick();
        in_valid = 1'b0;
        check("accept busy", 32'(busy), 32'd1);
        check("step R1 pre", 32'(r1), 32'd0);
        check("step out_valid", 32'(out_valid), 32'd0);
        check("step in_ready", 32'(in_ready), 32'd0);
        tick();
        check("settle R1", 32'(r1), 32'd1);
        check("settle out_valid", 32'(out_valid), 32'd0);
        tick();
        check("emit out_valid", 32'(out_valid), 32'd1);
        check("emit out_let", 32'(out_let), 32'd21);
        check_rotors("first letter", 5'd1, 5'd0, 5'd0);
        consume("first letter");

        foreach (tbl[i]) begin
            if (tbl[i].is_load) begin
                do_load(tbl[i].sel, tbl[i].val);
                check_rotors(tbl[i].name, tbl[i].e1, tbl[i].e2, tbl[i].e3);
            end else begin
                send_letter(tbl[i].val);
                check({tbl[i].name, " out_let"}, 32'(out_let), 32'(tbl[i].eout));
                check_rotors(tbl[i].name, tbl[i].e1, tbl[i].e2, tbl[i].e3);
                consume(tbl[i].name);
            end
        end

        // Backpressure in EMIT with config and letter requests that must be ignored.
        send_letter(5'd5);
        cfg_ld = 1'b1; cfg_sel = 2'd1; cfg_val = 5'd3;
        in_valid = 1'b1; in_let = 5'd9;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp out_let", 32'(out_let), 32'd17);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        cfg_ld = 1'b0; in_valid = 1'b0;
        check_rotors("bp", 5'd18, 5'd6, 5'd0);
        consume("bp");
        check("bp in_ready after", 32'(in_ready), 32'd1);

        // Config and letter in the same IDLE cycle: config wins.
        cfg_ld = 1'b1; cfg_sel = 2'd3; cfg_val = 5'd9;
        in_valid = 1'b1; in_let = 5'd2;
        #1;
        check("collide in_ready", 32'(in_ready), 32'd0);
        tick();
        cfg_ld = 1'b0; in_valid = 1'b0;
        check("collide busy", 32'(busy), 32'd0);
        check_rotors("collide", 5'd18, 5'd6, 5'd9);

        // Out-of-range letter is dropped.
        in_valid = 1'b1; in_let = 5'd27;
        tick();
        in_valid = 1'b0;
        check("bad letter busy", 32'(busy), 32'd0);
        tick();
        tick();
        check("bad letter out_valid", 32'(out_valid), 32'd0);
        check_rotors("bad letter", 5'd18, 5'd6, 5'd9);

        // Reset during SETTLE discards the operation.
        in_valid = 1'b1; in_let = 5'd4;
        tick();
        in_valid = 1'b0;
        tick();
        check("abort in settle", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        check_rotors("abort", 5'd0, 5'd0, 5'd0);
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("abort in_ready after", 32'(in_ready), 32'd1);
        tick();
        check("abort out_valid later", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
